alu_ctrl_skid: RTL

ALU_CTRL_SKID -- requirements
Module: alu_ctrl_skid

---
 rtl/alu_ctrl_skid.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_skid.sv
// alu_ctrl_skid: LEGv8 ALU-control decode in front of a 2-entry skid buffer
// between ID and EX. Decode happens on the input side; the decoded entry is
// stored with its operands, and the head slot drives every out_* signal.
module alu_ctrl_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_opcode,
  input  logic [1:0]  in_aluop,
  input  logic [63:0] in_op_a,
  input  logic [63:0] in_op_b,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alucnt,
  output logic        out_illegal,
  output logic [63:0] out_op_a,
  output logic [63:0] out_op_b,
  output logic [4:0]  out_rd,
  output logic [1:0]  occupancy
);

  localparam int unsigned OPC_W  = 11;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OPC_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR = 11'b10101010000;

  localparam logic [CNT_W-1:0] CNT_AND  = 4'b0000;
  localparam logic [CNT_W-1:0] CNT_ORR  = 4'b0001;
  localparam logic [CNT_W-1:0] CNT_ADD  = 4'b0010;
  localparam logic [CNT_W-1:0] CNT_SUB  = 4'b0110;
  localparam logic [CNT_W-1:0] CNT_PASS = 4'b0111;
  localparam logic [CNT_W-1:0] CNT_ILL  = 4'b1111;

  typedef struct packed {
    logic [CNT_W-1:0]  alucnt;
    logic              illegal;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [RD_W-1:0]   rd;
  } entry_t;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  entry_t head, tail;
  entry_t entry_in;

  logic push, pop;
  logic load_head, load_tail, head_from_tail;

  // Input-side ALU-control decode, bundled with the payload.
  always_comb begin
    entry_in.alucnt  = CNT_ILL;
    entry_in.illegal = 1'b1;
    entry_in.op_a    = in_op_a;
    entry_in.op_b    = in_op_b;
    entry_in.rd      = in_rd;
    unique case (in_aluop)
      2'b00: begin
        entry_in.alucnt  = CNT_ADD;
        entry_in.illegal = 1'b0;
      end
      2'b01: begin
        entry_in.alucnt  = CNT_PASS;
        entry_in.illegal = 1'b0;
      end
      2'b10: begin
        if (in_opcode == OPC_ADD) begin
          entry_in.alucnt  = CNT_ADD;
          entry_in.illegal = 1'b0;
        end else if (in_opcode == OPC_SUB) begin
          entry_in.alucnt  = CNT_SUB;
          entry_in.illegal = 1'b0;
        end else if (in_opcode == OPC_AND) begin
          entry_in.alucnt  = CNT_AND;
          entry_in.illegal = 1'b0;
        end else if (in_opcode == OPC_ORR) begin
          entry_in.alucnt  = CNT_ORR;
          entry_in.illegal = 1'b0;
        end
      end
      default: begin
        entry_in.alucnt  = CNT_ILL;
        entry_in.illegal = 1'b1;
      end
    endcase
  end

  // Handshake terms derive only from registered state.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = 2'(state);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head payload; control code and illegal flag are forced quiet when empty.
  assign out_alucnt  = out_valid ? head.alucnt : CNT_AND;
  assign out_illegal = out_valid & head.illegal;
  assign out_op_a    = head.op_a;
  assign out_op_b    = head.op_b;
  assign out_rd      = head.rd;

  // State register; reset dominates flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Next-state and slot load enables; flush drops everything incl. a same-cycle push.
  always_comb begin
    state_nxt      = state;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            load_head = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            load_head = 1'b1;
          end else if (push) begin
            load_tail = 1'b1;
            state_nxt = ST_FULL;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_from_tail = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Payload slots carry no reset; their contents only matter while valid.
  always_ff @(posedge clk) begin
    if (load_head)           head <= entry_in;
    else if (head_from_tail) head <= tail;
    if (load_tail)           tail <= entry_in;
  end

endmodule
